flag_unit: RTL and testbench
============================

Name: flag_unit

Overview:
- Producer side of the NZCV condition-flag interface that the condition-check logic consumes.
- Derives N, Z, C and V from the execute-stage ALU operands and result, and holds the architectural NZCV register.
- Commits flag updates only for valid, condition-passing, non-stalled, non-flushed instructions.
- Provides a same-cycle forwarded flag value and a one-entry shadow copy for exception save/restore.

Parameters:
WIDTH, 32, datapath width of ALU operands and result (>= 2).

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  reset, asynchronous, active-low
valid_i  input  1  execute-stage instruction valid
stall_i  input  1  pipeline stall; blocks all register updates
flush_i  input  1  kills the execute-stage instruction
alu_op_i  input  2  00 ADD, 01 SUB, 10 AND, 11 ORR
src_a_i  input  WIDTH  ALU operand A
src_b_i  input  WIDTH  ALU operand B (unmodified, pre-inversion)
result_i  input  WIDTH  ALU result
carry_out_i  input  1  ALU adder carry-out
flag_write_i  input  2  bit1 enables the NZ update, bit0 enables the CV update
cond_pass_i  input  1  condition of the current instruction passed
save_i  input  1  copy architectural flags into the shadow register
restore_i  input  1  load architectural flags from the shadow register
flags_o  output  4  architectural {N,Z,C,V}
flags_fwd_o  output  4  value flags_o will take at the next edge
upd_o  output  1  registered pulse, 1 cycle after any flag commit
upd_count_o  output  16  commit counter (see Optional Feature)

Behaviour:
- Reset (rst_n_i low, asynchronous): flags_o=0000, shadow=0000, upd_o=0, upd_count_o=0. Reset mid-instruction discards any pending commit.
- Flag derivation, combinational, with msb = WIDTH-1:
  - N_new = result_i[msb].
  - Z_new = (result_i == 0).
  - ADD: C_new = carry_out_i; V_new = (a[msb]==b[msb]) & (result[msb]!=a[msb]).
  - SUB: C_new = carry_out_i (1 = no borrow); V_new = (a[msb]!=b[msb]) & (result[msb]!=a[msb]).
  - AND/ORR: C and V are never modified, regardless of flag_write_i[0].
- Commit enable: commit = valid_i & cond_pass_i & ~stall_i & ~flush_i & ~restore_i.
  - NZ are written when commit & flag_write_i[1].
  - CV are written when commit & flag_write_i[0] & (alu_op_i is ADD or SUB).
  - Unselected bits hold their value.
- Next-value priority: restore_i & ~stall_i loads shadow; else commit merges the enabled bits; else hold.
- flags_fwd_o presents this next value combinationally, with zero latency. When nothing is written, flags_fwd_o == flags_o.
- Save: save_i & ~stall_i loads shadow <= flags_o, i.e. the pre-update value, even if a commit occurs in the same cycle.
- Save and restore together: shadow <= flags_o and flags_o <= old shadow, i.e. a swap.
- upd_o <= (commit & |flag_write_i) | (restore_i & ~stall_i), registered, 1-cycle latency.
- Stall has priority over every state change. flush_i suppresses commit only; save and restore are unaffected by flush.

Optional Feature:
- Macro: FLAG_UNIT_STATS_EN.
- When defined: upd_count_o counts cycles in which a commit writes at least one flag bit. It increments on the same edge as the flag write and saturates at 16'hFFFF (no wrap). Restores are not counted.
- When undefined: no counter logic is built and upd_count_o is tied to 16'h0000.

Test Plan:
- WIDTH=32, ADD a=7FFFFFFF, b=00000001, res=80000000, cout=0, flag_write=11, valid=cond_pass=1 -> next cycle flags_o=1001 (N,V), upd_o=1.
- SUB a=5, b=5, res=0, cout=1, flag_write=11 -> flags_fwd_o=0110 in the same cycle; flags_o=0110 after the edge.
- Preload flags=0011. ANDS res=0, flag_write=11 -> flags_o=0111 (C,V preserved). Repeat with cond_pass=0 -> flags unchanged, upd_o=0.
- Commit-qualifying ADD with stall_i=1, then the same op with flush_i=1 -> flags_o unchanged in both cases, flags_fwd_o==flags_o, counter unchanged.
- flags=1000, save_i=1 concurrent with a commit to 0100 -> shadow=1000, flags=0100. Then restore_i=1 with a valid commit present -> flags=1000, commit ignored, upd_o=1.
- Assert rst_n_i low mid-cycle during a commit -> outputs 0 immediately, with no clock edge needed. With FLAG_UNIT_STATS_EN, 65540 commits -> upd_count_o=FFFF.

Source files
------------

// File: rtl/flag_unit.sv
// flag_unit: NZCV flag derivation, architectural flag register, forwarding and exception shadow copy.
// Optional commit counter built only when FLAG_UNIT_STATS_EN is defined.
module flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [1:0]       alu_op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic [WIDTH-1:0] result_i,
  input  logic             carry_out_i,
  input  logic [1:0]       flag_write_i,
  input  logic             cond_pass_i,
  input  logic             save_i,
  input  logic             restore_i,
  output logic [3:0]       flags_o,
  output logic [3:0]       flags_fwd_o,
  output logic             upd_o,
  output logic [15:0]      upd_count_o
);
  localparam int MSB = WIDTH - 1;
  logic [3:0] flags_q, flags_d, shadow_q, shadow_d;
  logic       upd_q, upd_d;
  logic       commit, wr_nz, wr_cv, do_restore, n_new, z_new, v_new;
  assign commit     = valid_i & cond_pass_i & ~stall_i & ~flush_i & ~restore_i;
  assign do_restore = restore_i & ~stall_i;
  assign wr_nz      = commit & flag_write_i[1];
  assign wr_cv      = commit & flag_write_i[0] & ~alu_op_i[1];
  assign n_new      = result_i[MSB];
  assign z_new      = ~|result_i;
  // ADD overflows on equal operand signs, SUB on differing signs; both need a result sign flip
  assign v_new      = ((src_a_i[MSB] ^ src_b_i[MSB]) == alu_op_i[0]) & (result_i[MSB] ^ src_a_i[MSB]);
  always_comb begin
    flags_d  = do_restore ? shadow_q :
               {wr_nz ? n_new : flags_q[3], wr_nz ? z_new : flags_q[2],
                wr_cv ? carry_out_i : flags_q[1], wr_cv ? v_new : flags_q[0]};
    shadow_d = (save_i & ~stall_i) ? flags_q : shadow_q;
    upd_d    = (commit & |flag_write_i) | do_restore;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      flags_q  <= 4'b0000;
      shadow_q <= 4'b0000;
      upd_q    <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      shadow_q <= shadow_d;
      upd_q    <= upd_d;
    end
  end
  assign flags_o     = flags_q;
  assign flags_fwd_o = flags_d;
  assign upd_o       = upd_q;
`ifdef FLAG_UNIT_STATS_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = ((wr_nz | wr_cv) & ~&cnt_q) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= 16'h0000;
    else cnt_q <= cnt_d;
  end
  assign upd_count_o = cnt_q;
`else
  assign upd_count_o = 16'h0000;
`endif
endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed and randomized checks of flag_unit against an arithmetic reference model.
module tb_flag_unit;
  logic        clk_i = 1'b0, rst_n_i = 1'b0;
  logic        valid_i, stall_i, flush_i, cond_pass_i, save_i, restore_i, carry_out_i;
  logic [1:0]  alu_op_i, flag_write_i;
  logic [31:0] src_a_i, src_b_i, result_i;
  logic [3:0]  flags_o, flags_fwd_o;
  logic        upd_o;
  logic [15:0] upd_count_o;
  int n_chk = 0, n_pass = 0;
  logic [3:0] m_flags = 4'b0, m_shadow = 4'b0, e_fwd, e_shadow;
  logic       m_upd = 1'b0, e_upd;
  int         m_cnt = 0, e_cnt;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  flag_unit #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .alu_op_i(alu_op_i), .src_a_i(src_a_i), .src_b_i(src_b_i), .result_i(result_i),
    .carry_out_i(carry_out_i), .flag_write_i(flag_write_i), .cond_pass_i(cond_pass_i),
    .save_i(save_i), .restore_i(restore_i), .flags_o(flags_o), .flags_fwd_o(flags_fwd_o),
    .upd_o(upd_o), .upd_count_o(upd_count_o)
  );

  always #5 clk_i = ~clk_i;

  // The bench computes a genuine ALU result and derives expected flags from integer arithmetic.
  task automatic drive(input logic v, cp, st, fl, input logic [1:0] op, input logic [31:0] a, b,
                       input logic [1:0] fw, input logic sv, rs);
    longint sa, sb, sr;
    logic [31:0] res;
    logic n, z, c, ov, commit, wnz, wcv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sr = 0;
    c  = 1'b0;
    case (op)
      2'd0: begin res = a + b; c = ({1'b0, a} + {1'b0, b}) > 33'hFFFFFFFF; sr = sa + sb; end
      2'd1: begin res = a - b; c = (a >= b); sr = sa - sb; end
      2'd2: res = a & b;
      default: res = a | b;
    endcase
    ov = (sr > MAXS) || (sr < MINS);
    n = res[31];
    z = (res == 32'd0);
    commit = v && cp && !st && !fl && !rs;
    wnz = commit && fw[1];
    wcv = commit && fw[0] && (op < 2);
    if (rs && !st) e_fwd = m_shadow;
    else begin
      e_fwd = m_flags;
      if (wnz) begin e_fwd[3] = n; e_fwd[2] = z; end
      if (wcv) begin e_fwd[1] = c; e_fwd[0] = ov; end
    end
    e_shadow = (sv && !st) ? m_flags : m_shadow;
    e_upd = (commit && fw != 2'b00) || (rs && !st);
    e_cnt = m_cnt;
`ifdef FLAG_UNIT_STATS_EN
    if ((wnz || wcv) && m_cnt < 65535) e_cnt = m_cnt + 1;
`endif
    valid_i = v; cond_pass_i = cp; stall_i = st; flush_i = fl; alu_op_i = op;
    src_a_i = a; src_b_i = b; result_i = res; carry_out_i = c; flag_write_i = fw;
    save_i = sv; restore_i = rs;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 2'd0, 32'd0, 32'd0, 2'b00, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    m_flags = e_fwd; m_shadow = e_shadow; m_upd = e_upd; m_cnt = e_cnt;
  endtask

  task automatic test_reset();
    idle();
    #12;
    n_chk++; if (flags_o !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", flags_o); else n_pass++;
    n_chk++; if (upd_o !== 1'b0) $display("FAIL reset_upd got=%b exp=0", upd_o); else n_pass++;
    n_chk++; if (upd_count_o !== 16'h0) $display("FAIL reset_cnt got=%h exp=0000", upd_count_o); else n_pass++;
    n_chk++; if (flags_fwd_o !== 4'b0000) $display("FAIL reset_fwd got=%b exp=0000", flags_fwd_o); else n_pass++;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_add_overflow();
    drive(1, 1, 0, 0, 2'd0, 32'h7FFFFFFF, 32'h00000001, 2'b11, 0, 0);
    tick();
    n_chk++; if (flags_o !== 4'b1001) $display("FAIL add_ovf_flags got=%b exp=1001", flags_o); else n_pass++;
    n_chk++; if (upd_o !== 1'b1) $display("FAIL add_ovf_upd got=%b exp=1", upd_o); else n_pass++;
  endtask

  task automatic test_sub_zero();
    drive(1, 1, 0, 0, 2'd1, 32'd5, 32'd5, 2'b11, 0, 0);
    #1;
    n_chk++; if (flags_fwd_o !== 4'b0110) $display("FAIL sub_fwd got=%b exp=0110", flags_fwd_o); else n_pass++;
    tick();
    n_chk++; if (flags_o !== 4'b0110) $display("FAIL sub_flags got=%b exp=0110", flags_o); else n_pass++;
  endtask

  task automatic test_logic_preserve();
    drive(1, 1, 0, 0, 2'd0, 32'h80000000, 32'hFFFFFFFF, 2'b11, 0, 0);
    tick();
    n_chk++; if (flags_o !== 4'b0011) $display("FAIL preload got=%b exp=0011", flags_o); else n_pass++;
    drive(1, 1, 0, 0, 2'd2, 32'h0000000F, 32'h000000F0, 2'b11, 0, 0);
    tick();
    n_chk++; if (flags_o !== 4'b0111) $display("FAIL ands_flags got=%b exp=0111", flags_o); else n_pass++;
    drive(1, 0, 0, 0, 2'd2, 32'h80000000, 32'h80000000, 2'b11, 0, 0);
    tick();
    n_chk++; if (flags_o !== 4'b0111) $display("FAIL ands_nopass_flags got=%b exp=0111", flags_o); else n_pass++;
    n_chk++; if (upd_o !== 1'b0) $display("FAIL ands_nopass_upd got=%b exp=0", upd_o); else n_pass++;
  endtask

  task automatic test_stall_flush();
    logic [15:0] cnt0;
    cnt0 = upd_count_o;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, i == 0, i == 1, 2'd1, 32'd3, 32'd9, 2'b11, 0, 0);
      #1;
      n_chk++; if (flags_fwd_o !== 4'b0111) $display("FAIL blocked_fwd[%0d] got=%b exp=0111", i, flags_fwd_o); else n_pass++;
      tick();
      n_chk++; if (flags_o !== 4'b0111) $display("FAIL blocked_flags[%0d] got=%b exp=0111", i, flags_o); else n_pass++;
      n_chk++; if (upd_count_o !== cnt0) $display("FAIL blocked_cnt[%0d] got=%h exp=%h", i, upd_count_o, cnt0); else n_pass++;
      n_chk++; if (upd_o !== 1'b0) $display("FAIL blocked_upd[%0d] got=%b exp=0", i, upd_o); else n_pass++;
    end
  endtask

  task automatic test_save_restore();
    drive(1, 1, 0, 0, 2'd0, 32'h00000000, 32'h80000000, 2'b11, 0, 0);
    tick();
    n_chk++; if (flags_o !== 4'b1000) $display("FAIL sr_preload got=%b exp=1000", flags_o); else n_pass++;
    drive(1, 1, 0, 0, 2'd1, 32'd5, 32'd5, 2'b10, 1, 0);
    tick();
    n_chk++; if (flags_o !== 4'b0100) $display("FAIL save_commit got=%b exp=0100", flags_o); else n_pass++;
    drive(1, 1, 0, 0, 2'd0, 32'h7FFFFFFF, 32'd1, 2'b11, 0, 1);
    #1;
    n_chk++; if (flags_fwd_o !== 4'b1000) $display("FAIL restore_fwd got=%b exp=1000", flags_fwd_o); else n_pass++;
    tick();
    n_chk++; if (flags_o !== 4'b1000) $display("FAIL restore_flags got=%b exp=1000", flags_o); else n_pass++;
    n_chk++; if (upd_o !== 1'b1) $display("FAIL restore_upd got=%b exp=1", upd_o); else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] op;
    for (int i = 0; i < 400; i++) begin
      op = 2'($urandom_range(0, 3));
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 5) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, op, $urandom(), ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom(),
            2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      #1;
      n_chk++; if (flags_fwd_o !== e_fwd) $display("FAIL rnd_fwd[%0d] got=%b exp=%b", i, flags_fwd_o, e_fwd); else n_pass++;
      tick();
      n_chk++; if (flags_o !== m_flags) $display("FAIL rnd_flags[%0d] got=%b exp=%b", i, flags_o, m_flags); else n_pass++;
      n_chk++; if (upd_o !== m_upd) $display("FAIL rnd_upd[%0d] got=%b exp=%b", i, upd_o, m_upd); else n_pass++;
      n_chk++; if (upd_count_o !== 16'(m_cnt)) $display("FAIL rnd_cnt[%0d] got=%h exp=%h", i, upd_count_o, 16'(m_cnt)); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    drive(1, 1, 0, 0, 2'd0, 32'h80000000, 32'h80000000, 2'b11, 0, 0);
    tick();
    drive(1, 1, 0, 0, 2'd0, 32'h7FFFFFFF, 32'd1, 2'b11, 1, 0);
    #2;
    rst_n_i = 1'b0;
    #1;
    n_chk++; if (flags_o !== 4'b0000) $display("FAIL async_flags got=%b exp=0000", flags_o); else n_pass++;
    n_chk++; if (upd_o !== 1'b0) $display("FAIL async_upd got=%b exp=0", upd_o); else n_pass++;
    n_chk++; if (upd_count_o !== 16'h0) $display("FAIL async_cnt got=%h exp=0000", upd_count_o); else n_pass++;
    m_flags = 4'b0; m_shadow = 4'b0; m_upd = 1'b0; m_cnt = 0;
    idle();
    #2;
    rst_n_i = 1'b1;
    tick();
    drive(0, 0, 0, 0, 2'd0, 32'd0, 32'd0, 2'b00, 0, 1);
    tick();
    n_chk++; if (flags_o !== 4'b0000) $display("FAIL async_shadow got=%b exp=0000", flags_o); else n_pass++;
  endtask

`ifdef FLAG_UNIT_STATS_EN
  task automatic test_saturation();
    for (int i = 0; i < 65540; i++) begin
      drive(1, 1, 0, 0, 2'd1, 32'd7, 32'd7, 2'b11, 0, 0);
      tick();
    end
    n_chk++; if (upd_count_o !== 16'hFFFF) $display("FAIL sat_cnt got=%h exp=ffff", upd_count_o); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_logic_preserve();
    test_stall_flush();
    test_save_restore();
    test_random();
    test_async_reset();
`ifdef FLAG_UNIT_STATS_EN
    test_saturation();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
